// File: rtl/bit_destuffing_if.sv
// Bit-stream bundle between the CAN bit sampler, the destuffer and the frame deserializer.
// The master side drives the sampled bits and frame control; the slave side returns destuffed bits.
interface bit_destuffing_if #(
  parameter int ERR_CNT_W = 8
);

  logic                 data_in;
  logic                 data_valid;
  logic                 stuff_en;
  logic                 frame_start;
  logic                 frame_end;
  logic                 err_clear;
  logic                 data_out;
  logic                 data_out_valid;
  logic                 stuff_bit_drop;
  logic                 stuff_error;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output data_in, data_valid, stuff_en, frame_start, frame_end, err_clear,
    input  data_out, data_out_valid, stuff_bit_drop, stuff_error, err_count
  );

  modport slave (
    input  data_in, data_valid, stuff_en, frame_start, frame_end, err_clear,
    output data_out, data_out_valid, stuff_bit_drop, stuff_error, err_count
  );

endinterface

// File: rtl/bit_destuffing.sv
// Receive-side CAN bit destuffer: drops the complementary bit after RUN_LEN identical bits, flags missing ones.
// Optional saturating stuff-error counter is built when STUFF_ERR_CNT_EN is defined.
module bit_destuffing #(
  parameter int RUN_LEN   = 5,
  parameter int ERR_CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  bit_destuffing_if.slave bus
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STUFF,
    ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;

  state_t           cur_state;
  logic [CNT_W-1:0] cur_run;
  logic             cur_last;
  logic             closing;
  logic [CNT_W-1:0] bumped;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      last_q  <= 1'b1;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  // Frame control first rewrites the tracking context, then any same-cycle bit is judged against it.
  // A frame_end bit is treated as a plain data bit, which discards a pending stuff check.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    last_d    = last_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    drop_d    = 1'b0;
    err_d     = err_q;
    cur_state = state_q;
    cur_run   = run_q;
    cur_last  = last_q;
    closing   = 1'b0;
    bumped    = '0;

    if (bus.frame_start) begin
      cur_state = RUN;
      cur_run   = '0;
      cur_last  = 1'b1;
      state_d   = RUN;
      run_d     = '0;
      last_d    = 1'b1;
      err_d     = 1'b0;
    end else if (bus.frame_end && (state_q == RUN || state_q == STUFF)) begin
      cur_state = RUN;
      closing   = 1'b1;
      state_d   = IDLE;
    end else if (bus.err_clear && state_q == ERROR) begin
      cur_state = IDLE;
      state_d   = IDLE;
      err_d     = 1'b0;
    end

    if (bus.data_valid) begin
      case (cur_state)
        RUN: begin
          bumped  = (cur_run == RUN_MAX) ? RUN_MAX : cur_run + RUN_ONE;
          out_d   = bus.data_in;
          valid_d = 1'b1;
          last_d  = bus.data_in;
          if (!bus.stuff_en) begin
            run_d = '0;
          end else if (bus.data_in == cur_last) begin
            run_d = bumped;
          end else begin
            run_d = RUN_ONE;
          end
          if (!closing && bus.stuff_en && run_d == RUN_MAX) begin
            state_d = STUFF;
          end
        end
        STUFF: begin
          if (bus.data_in != cur_last) begin
            drop_d  = 1'b1;
            run_d   = RUN_ONE;
            last_d  = bus.data_in;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_out       = out_q;
  assign bus.data_out_valid = valid_q;
  assign bus.stuff_bit_drop = drop_q;
  assign bus.stuff_error    = err_q;

`ifdef STUFF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 enter_err;

  // ERROR is only ever entered from a failed stuff check, so any entry counts once.
  assign enter_err = (state_d == ERROR) && (state_q != ERROR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (enter_err && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_bit_destuffing.sv
// Bench for bit_destuffing: directed frames plus random traffic against a queue-based destuffing model.
// Follows STUFF_ERR_CNT_EN the same way the design does.
module tb_bit_destuffing;

  localparam int RUN_LEN   = 5;
  localparam int ERR_CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  bit_destuffing_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  bit_destuffing #(
    .RUN_LEN  (RUN_LEN),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: frame mode (0 idle, 1 active, 2 error), recent unstuffed-stream bits, pending stuff check.
  int                   m_mode;
  bit                   hist[$];
  bit                   m_pend;
  logic                 e_out, e_valid, e_drop, e_err;
  logic [ERR_CNT_W-1:0] e_cnt;

  logic got_q[$];
  int   got_drops;

  logic s_din, s_dv, s_fs, s_fe, s_ec, s_se, s_rst;
  bit   proc, ending;
  logic prev_bit;

  function automatic void check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int trailing_run();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    s_din = bus.data_in;
    s_dv  = bus.data_valid;
    s_fs  = bus.frame_start;
    s_fe  = bus.frame_end;
    s_ec  = bus.err_clear;
    s_se  = bus.stuff_en;
    s_rst = rst;

    if (!s_rst) begin
      m_mode  = 0;
      hist.delete();
      m_pend  = 1'b0;
      e_out   = 1'b0;
      e_valid = 1'b0;
      e_drop  = 1'b0;
      e_err   = 1'b0;
      e_cnt   = '0;
    end else begin
      e_valid = 1'b0;
      e_drop  = 1'b0;
      proc    = 1'b0;
      ending  = 1'b0;
      if (s_fs) begin
        m_mode = 1;
        hist.delete();
        m_pend = 1'b0;
        e_err  = 1'b0;
        proc   = 1'b1;
      end else if (s_fe && m_mode == 1) begin
        proc   = 1'b1;
        ending = 1'b1;
      end else if (s_ec && m_mode == 2) begin
        m_mode = 0;
        e_err  = 1'b0;
      end else if (m_mode == 1) begin
        proc = 1'b1;
      end

      if (proc && s_dv) begin
        if (m_pend && !ending) begin
          if (s_din != hist[$]) begin
            e_drop = 1'b1;
            hist.push_back(s_din);
            m_pend = 1'b0;
          end else begin
            e_err  = 1'b1;
            m_mode = 2;
            m_pend = 1'b0;
`ifdef STUFF_ERR_CNT_EN
            if (e_cnt != {ERR_CNT_W{1'b1}}) e_cnt = e_cnt + 1'b1;
`endif
          end
        end else begin
          e_out   = s_din;
          e_valid = 1'b1;
          if (s_se) begin
            hist.push_back(s_din);
            if (trailing_run() >= RUN_LEN) m_pend = 1'b1;
          end else begin
            hist.delete();
          end
        end
      end

      if (ending) begin
        m_mode = 0;
        m_pend = 1'b0;
      end
      if (hist.size() > RUN_LEN + 1) void'(hist.pop_front());
    end

    #1;
    if (bus.data_out_valid === 1'b1) got_q.push_back(bus.data_out);
    if (bus.stuff_bit_drop === 1'b1) got_drops++;
    check1("data_out_valid", 32'(bus.data_out_valid), 32'(e_valid));
    check1("stuff_bit_drop", 32'(bus.stuff_bit_drop), 32'(e_drop));
    check1("stuff_error",    32'(bus.stuff_error),    32'(e_err));
    check1("data_out",       32'(bus.data_out),       32'(e_out));
    check1("err_count",      32'(bus.err_count),      32'(e_cnt));
  end

  task automatic applyStimulus(input logic din, input logic dv, input logic fs,
                               input logic fe, input logic ec);
    @(negedge clk);
    bus.data_in     = din;
    bus.data_valid  = dv;
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.err_clear   = ec;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bits are sent LSB first; gap_max > 0 inserts 1..gap_max idle cycles after each bit.
  task automatic sendBits(input logic [31:0] bits, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      applyStimulus(bits[i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (gap_max > 0) idleCycles(int'($urandom_range(1, gap_max)));
    end
  endtask

  task automatic checkOutput(input string name, input int exp_n, input logic [31:0] exp_bits,
                             input int exp_drops, input logic exp_err);
    check1($sformatf("%s_count", name), 32'(got_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < got_q.size(); i++)
      check1($sformatf("%s_bit%0d", name, i), 32'(got_q[i]), 32'(exp_bits[i]));
    check1($sformatf("%s_drops", name), 32'(got_drops), 32'(exp_drops));
    check1($sformatf("%s_error", name), 32'(bus.stuff_error), 32'(exp_err));
    got_q.delete();
    got_drops = 0;
  endtask

  initial begin
    rst             = 1'b0;
    bus.data_in     = 1'b0;
    bus.data_valid  = 1'b0;
    bus.stuff_en    = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.err_clear   = 1'b0;
    got_drops       = 0;
    prev_bit        = 1'b0;

    idleCycles(2);
    rst = 1'b1;
    idleCycles(1);
    check1("reset_data_out", 32'(bus.data_out), 32'd0);
    check1("reset_err_count", 32'(bus.err_count), 32'd0);
    checkOutput("reset", 0, 32'd0, 0, 1'b0);

    $display("[TB] scenario 1: stuffed run of zeros");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    sendBits(32'b010000, 6, 0);
    idleCycles(2);
    checkOutput("s1", 6, 32'b000000, 1, 1'b0);

    $display("[TB] scenario 2: missing stuff bit");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(32'b111111, 6, 0);
    idleCycles(2);
    checkOutput("s2", 5, 32'b11111, 0, 1'b1);
    sendBits(32'b0110, 4, 0);
    idleCycles(2);
    checkOutput("s2_ignored", 0, 32'd0, 0, 1'b1);
`ifdef STUFF_ERR_CNT_EN
    check1("s2_err_count", 32'(bus.err_count), 32'd1);
`else
    check1("s2_err_count", 32'(bus.err_count), 32'd0);
`endif

    $display("[TB] scenario 3: back-to-back stuff bits");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(32'hBE0, 12, 0);
    idleCycles(2);
    checkOutput("s3", 10, 32'h3E0, 2, 1'b0);

    $display("[TB] scenario 4: pass-through and err_clear");
    bus.stuff_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(32'h00, 8, 0);
    idleCycles(2);
    checkOutput("s4", 8, 32'h00, 0, 1'b0);
    bus.stuff_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(32'b111111, 6, 0);
    idleCycles(2);
    checkOutput("s4_err", 5, 32'b11111, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(1);
    sendBits(32'b0101, 4, 0);
    idleCycles(2);
    checkOutput("s4_clear", 0, 32'd0, 0, 1'b0);

    $display("[TB] scenario 5: gapped input");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(32'b0100000, 7, 3);
    idleCycles(2);
    checkOutput("s5", 6, 32'b000000, 1, 1'b0);

    $display("[TB] scenario 6: reset while checking a stuff bit");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sendBits(32'b00000, 5, 0);
    idleCycles(1);
    checkOutput("s6_pre", 5, 32'd0, 0, 1'b0);
    @(negedge clk);
    rst            = 1'b0;
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    check1("s6_rst_valid", 32'(bus.data_out_valid), 32'd0);
    check1("s6_rst_error", 32'(bus.stuff_error), 32'd0);
    sendBits(32'b00000, 5, 0);
    idleCycles(2);
    checkOutput("s6_idle", 0, 32'd0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    sendBits(32'b010000, 6, 0);
    idleCycles(2);
    checkOutput("s6_after", 6, 32'b000000, 1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 1499) != 0);
      if (bus.stuff_en) bus.stuff_en = ($urandom_range(0, 399) != 0);
      else              bus.stuff_en = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) >= 8) prev_bit = ~prev_bit;
      bus.data_in     = prev_bit;
      bus.data_valid  = ($urandom_range(0, 2) != 0);
      bus.frame_start = (m_mode != 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
      bus.frame_end   = ($urandom_range(0, 249) == 0);
      bus.err_clear   = ($urandom_range(0, 29) == 0);
    end
    rst = 1'b1;
    idleCycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
